// File: rtl/axi_mst_read_ot.sv
// -----------------------------------------------------------------------------
// axi_mst_read_ot
// AXI3 read master that streams a run of fixed-length INCR bursts into an
// AXI-Stream sink while keeping up to MAX_OUTST bursts outstanding.
//
// Ports
//   clk, rst            : sole clock, synchronous active-high reset
//   START_REG           : level input, a rising edge requests a run
//   ADDR_REG, NBURST_REG: start byte address and burst count, latched at start
//   RIDLE_REG           : high while idle
//   DONE                : one-cycle pulse at the end of a run
//   RERR                : sticky, any non-OKAY rresp seen since the last start
//   m_axi_ar*           : AXI3 read address channel (master side)
//   m_axi_r*            : AXI3 read data channel, passed straight to m_axis_*
//   m_axis_t*           : AXI-Stream output
//   CYC_CNT, BEAT_CNT   : run cycle count / accepted R beats
//
// Configuration
//   AXI_MST_READ_OT_BW_CNT_EN : when defined, builds the saturating
//   CYC_CNT/BEAT_CNT counters; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module axi_mst_read_ot #(
  parameter int ID_WIDTH       = 6,
  parameter int DATA_WIDTH     = 64,
  parameter int B_BURST_LENGTH = 4,
  parameter int BURST_LENGTH   = 15,
  parameter int MAX_OUTST      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      START_REG,
  input  logic [31:0]               ADDR_REG,
  input  logic [31:0]               NBURST_REG,
  output logic                      RIDLE_REG,
  output logic                      DONE,
  output logic                      RERR,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [31:0]               m_axi_araddr,
  output logic [B_BURST_LENGTH-1:0] m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [1:0]                m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [31:0]               CYC_CNT,
  output logic [31:0]               BEAT_CNT
);

  // Byte stride between consecutive bursts.
  localparam logic [31:0] BURST_BYTES = 32'((BURST_LENGTH + 1) * DATA_WIDTH / 8);
  // Outstanding counter is 5 bits wide, enough for MAX_OUTST up to 16.
  localparam logic [4:0]  MAX_OUT_L   = 5'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        start_d_r;
  logic        start_pulse_r;
  logic        arvalid_r;
  logic [31:0] addr_r;
  logic [31:0] rem_r;
  logic [4:0]  out_r;
  logic        rerr_r;

  logic        ar_hs_s;
  logic        r_hs_s;
  logic        out_dec_s;
  logic        start_any_s;
  logic [4:0]  out_next_s;
  logic        unused_s;

  // rid is not needed: all bursts use ID 0 and return in order.
  assign unused_s    = ^m_axi_rid;

  assign ar_hs_s     = arvalid_r & m_axi_arready;
  assign r_hs_s      = m_axi_rvalid & m_axis_tready;
  // A stray rlast (e.g. from a burst abandoned by reset) never drives the count below zero.
  assign out_dec_s   = r_hs_s & m_axi_rlast & (out_r != 5'd0);
  assign start_any_s = (state_r == ST_IDLE) & start_pulse_r;

  // Next outstanding-burst count; simultaneous issue and completion cancel out.
  always_comb begin
    out_next_s = out_r;
    if (ar_hs_s && !out_dec_s) begin
      out_next_s = out_r + 5'd1;
    end else if (!ar_hs_s && out_dec_s) begin
      out_next_s = out_r - 5'd1;
    end else begin
      out_next_s = out_r;
    end
  end

  // Run sequencer: start edge detect, AR issue, outstanding tracking and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      // Track the live level so a START held high across reset is not a new request.
      start_d_r     <= START_REG;
      start_pulse_r <= 1'b0;
      arvalid_r     <= 1'b0;
      addr_r        <= 32'd0;
      rem_r         <= 32'd0;
      out_r         <= 5'd0;
      rerr_r        <= 1'b0;
    end else begin
      start_d_r     <= START_REG;
      start_pulse_r <= START_REG & ~start_d_r;
      out_r         <= out_next_s;

      if (start_any_s) begin
        rerr_r <= 1'b0;
      end else if (r_hs_s && (m_axi_rresp != 2'b00)) begin
        rerr_r <= 1'b1;
      end else begin
        rerr_r <= rerr_r;
      end

      case (state_r)
        ST_IDLE: begin
          arvalid_r <= 1'b0;
          if (start_pulse_r) begin
            if (NBURST_REG != 32'd0) begin
              addr_r    <= ADDR_REG;
              rem_r     <= NBURST_REG;
              arvalid_r <= 1'b1;
              state_r   <= ST_ISSUE;
            end else begin
              state_r   <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (ar_hs_s) begin
            addr_r <= addr_r + BURST_BYTES;
            rem_r  <= rem_r - 32'd1;
            if (rem_r == 32'd1) begin
              arvalid_r <= 1'b0;
              state_r   <= ST_DRAIN;
            end else begin
              arvalid_r <= (out_next_s < MAX_OUT_L);
            end
          end else begin
            // Once raised, arvalid stays up with a stable address until accepted.
            arvalid_r <= arvalid_r | (out_next_s < MAX_OUT_L);
          end
        end
        ST_DRAIN: begin
          arvalid_r <= 1'b0;
          if (out_r == 5'd0) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          arvalid_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          arvalid_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign RIDLE_REG     = (state_r == ST_IDLE);
  assign DONE          = (state_r == ST_DONE);
  assign RERR          = rerr_r;

  assign m_axi_arvalid = arvalid_r;
  assign m_axi_araddr  = addr_r;
  assign m_axi_arid    = {ID_WIDTH{1'b0}};
  assign m_axi_arlen   = B_BURST_LENGTH'(BURST_LENGTH);
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 2'b00;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  // R channel goes straight through to the stream with no buffering.
  assign m_axis_tvalid = m_axi_rvalid;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tlast  = m_axi_rlast;
  assign m_axis_tstrb  = {(DATA_WIDTH/8){1'b1}};
  assign m_axi_rready  = m_axis_tready;

`ifdef AXI_MST_READ_OT_BW_CNT_EN
  logic [31:0] cyc_cnt_r;
  logic [31:0] beat_cnt_r;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Bandwidth counters: the accept cycle counts as 1, then every non-idle cycle
  // through DONE; both values hold once the run is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_r  <= 32'd0;
      beat_cnt_r <= 32'd0;
    end else if (start_any_s) begin
      cyc_cnt_r  <= 32'd1;
      beat_cnt_r <= 32'd0;
    end else begin
      if (state_r != ST_IDLE) begin
        cyc_cnt_r <= sat_inc(cyc_cnt_r);
      end
      if (((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) && r_hs_s) begin
        beat_cnt_r <= sat_inc(beat_cnt_r);
      end
    end
  end

  assign CYC_CNT  = cyc_cnt_r;
  assign BEAT_CNT = beat_cnt_r;
`else
  assign CYC_CNT  = 32'd0;
  assign BEAT_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_axi_mst_read_ot.sv
// Self-checking bench for axi_mst_read_ot: an in-order AXI read slave with
// programmable latency, a scoreboard of expected AR addresses and R data
// derived from the run's address arithmetic, and scenario tasks.
module tb_axi_mst_read_ot;
  localparam int BL   = 15;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        START_REG = 1'b0;
  logic [31:0] ADDR_REG = 32'd0;
  logic [31:0] NBURST_REG = 32'd0;
  logic        RIDLE_REG, DONE, RERR;
  logic [5:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst, m_axi_arlock;
  logic [3:0]  m_axi_arcache, m_axi_arqos;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b1;
  logic [5:0]  m_axi_rid = 6'd0;
  logic [63:0] m_axi_rdata = 64'd0;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic        m_axis_tvalid, m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tstrb;
  logic        m_axis_tready = 1'b1;
  logic [31:0] CYC_CNT, BEAT_CNT;

  axi_mst_read_ot #(.ID_WIDTH(6), .DATA_WIDTH(64), .B_BURST_LENGTH(4),
                    .BURST_LENGTH(BL), .MAX_OUTST(MAXO)) dut (
    .clk(clk), .rst(rst), .START_REG(START_REG), .ADDR_REG(ADDR_REG),
    .NBURST_REG(NBURST_REG), .RIDLE_REG(RIDLE_REG), .DONE(DONE), .RERR(RERR),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tstrb(m_axis_tstrb), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .CYC_CNT(CYC_CNT), .BEAT_CNT(BEAT_CNT));

  initial forever #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int rdy; } ar_t;
  ar_t         ar_q[$];
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];

  int tests = 0, fails = 0;
  int cyc = 0, lat = 10, ar_mode = 0, tr_mode = 0, ar_stall = 0, err_idx = -1;
  int done_cnt = 0, run_beats = 0, run_ars = 0, run_arv = 0, busy_cyc = 0;
  int out_model = 0, max_out = 0, s_beat = 0;
  bit sb_en = 1'b1;

  logic        a_hs, r_hs, a_rst, a_last;
  logic        p_valid = 1'b0, p_hs = 1'b0, p_rst = 1'b1;
  logic [31:0] p_addr = 32'd0;

  function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
    logic [31:0] x;
    x = a + 32'(b * 8);
    return {x ^ 32'h5A5A_C3C3, x};
  endfunction

  // Slave model and per-cycle protocol monitor.
  initial begin : slave
    logic [31:0] ea;
    logic [63:0] ed;
    int dec;
    forever begin
      @(negedge clk);
      a_hs   = m_axi_arvalid && m_axi_arready;
      r_hs   = m_axi_rvalid && m_axi_rready;
      a_rst  = rst;
      a_last = m_axi_rlast;
      tests++;
      if (m_axi_rready !== m_axis_tready) begin
        fails++; $display("FAIL rready_track got %b exp %b", m_axi_rready, m_axis_tready);
      end
      tests++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {m_axi_rvalid, m_axi_rlast, m_axi_rdata}
          || m_axis_tstrb !== 8'hFF) begin
        fails++; $display("FAIL passthru got v%b l%b d%h s%h exp v%b l%b d%h s ff", m_axis_tvalid,
                          m_axis_tlast, m_axis_tdata, m_axis_tstrb, m_axi_rvalid, m_axi_rlast, m_axi_rdata);
      end
      if (p_valid && !p_hs && !p_rst) begin
        tests++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== p_addr) begin
          fails++; $display("FAIL ar_stable got v%b a%h exp v1 a%h", m_axi_arvalid, m_axi_araddr, p_addr);
        end
      end
      if (m_axi_arvalid === 1'b1) begin
        run_arv++;
        tests++;
        if (out_model >= MAXO) begin
          fails++; $display("FAIL ar_outst arvalid with %0d outstanding, limit %0d", out_model, MAXO);
        end
      end
      if (a_hs) begin
        run_ars++;
        if (sb_en) begin
          tests++;
          if (exp_addr_q.size() == 0) begin
            fails++; $display("FAIL ar_unexpected got addr %h exp no AR", m_axi_araddr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (m_axi_araddr !== ea) begin
              fails++; $display("FAIL ar_addr got %h exp %h", m_axi_araddr, ea);
            end
          end
          tests++;
          if (m_axi_arid !== 6'd0 || m_axi_arlen !== 4'd15 || m_axi_arsize !== 3'd3 ||
              m_axi_arburst !== 2'b01 || m_axi_arlock !== 2'b00 || m_axi_arcache !== 4'b0011 ||
              m_axi_arprot !== 3'd0 || m_axi_arqos !== 4'd0) begin
            fails++; $display("FAIL ar_const got id%h len%h size%h burst%h lock%h cache%h prot%h qos%h exp 0 f 3 1 0 3 0 0",
                              m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                              m_axi_arcache, m_axi_arprot, m_axi_arqos);
          end
        end
      end
      if (r_hs) begin
        if (sb_en) begin
          tests++;
          if (exp_data_q.size() == 0) begin
            fails++; $display("FAIL r_unexpected got %h exp no beat", m_axis_tdata);
          end else begin
            ed = exp_data_q.pop_front();
            if (m_axis_tdata !== ed) begin
              fails++; $display("FAIL stream_data got %h exp %h", m_axis_tdata, ed);
            end
          end
        end
        run_beats++;
      end
      if (DONE === 1'b1) done_cnt++;
      if (RIDLE_REG === 1'b0) busy_cyc++;
      if (ar_mode == 2 && m_axi_arvalid === 1'b1 && ar_stall > 0) ar_stall--;
      p_valid = m_axi_arvalid; p_hs = a_hs; p_rst = a_rst; p_addr = m_axi_araddr;

      @(posedge clk); #1;
      cyc++;
      if (a_hs) ar_q.push_back('{p_addr, cyc + lat});
      dec = (r_hs && a_last && out_model > 0) ? 1 : 0;
      if (a_rst) out_model = 0;
      else out_model = out_model + (a_hs ? 1 : 0) - dec;
      if (out_model > max_out) max_out = out_model;
      if (r_hs) begin
        if (a_last) begin
          if (ar_q.size() > 0) void'(ar_q.pop_front());
          s_beat = 0;
        end else begin
          s_beat++;
        end
      end
      case (ar_mode)
        1:       m_axi_arready = 1'($urandom_range(0, 1));
        2:       m_axi_arready = (ar_stall == 0);
        default: m_axi_arready = 1'b1;
      endcase
      case (tr_mode)
        1:       m_axis_tready = cyc[0];
        2:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b1;
      endcase
      if (ar_q.size() > 0 && cyc >= ar_q[0].rdy) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_data(ar_q[0].addr, s_beat);
        m_axi_rlast  = (s_beat == BL);
        m_axi_rresp  = (run_beats == err_idx) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = 64'd0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  end

  task automatic do_run(input logic [31:0] a, input int nb, input bit exp_rerr, input bit toggle);
    int guard, d0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < nb; i++) begin
      exp_addr_q.push_back(a + 32'(i) * 32'd128);
      for (int b = 0; b <= BL; b++) exp_data_q.push_back(beat_data(a + 32'(i) * 32'd128, b));
    end
    ADDR_REG = a;
    NBURST_REG = 32'(nb);
    @(posedge clk); #1;
    run_beats = 0; run_ars = 0; busy_cyc = 0; max_out = 0; d0 = done_cnt;
    START_REG = 1'b1;
    guard = 0;
    while (done_cnt == d0 && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
      if (toggle && guard == 30) START_REG = 1'b0;
      if (toggle && guard == 32) START_REG = 1'b1;
    end
    tests++;
    if (guard >= 5000) begin fails++; $display("FAIL run_timeout addr %h got no DONE exp DONE", a); end
    repeat (40) @(posedge clk);
    #1;
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL done_count got %0d exp 1", done_cnt - d0); end
    tests++;
    if (exp_addr_q.size() != 0) begin fails++; $display("FAIL ar_count got %0d missing exp 0", exp_addr_q.size()); end
    tests++;
    if (run_beats != nb * 16) begin fails++; $display("FAIL beat_count got %0d exp %0d", run_beats, nb * 16); end
    tests++;
    if (max_out > MAXO) begin fails++; $display("FAIL max_outst got %0d exp <= %0d", max_out, MAXO); end
    tests++;
    if (RERR !== exp_rerr) begin fails++; $display("FAIL rerr got %b exp %b", RERR, exp_rerr); end
    tests++;
    if (RIDLE_REG !== 1'b1 || m_axi_arvalid !== 1'b0) begin
      fails++; $display("FAIL end_idle got ridle %b arvalid %b exp 1 0", RIDLE_REG, m_axi_arvalid);
    end
`ifdef AXI_MST_READ_OT_BW_CNT_EN
    tests++;
    if (BEAT_CNT !== 32'(nb * 16)) begin fails++; $display("FAIL beat_cnt got %0d exp %0d", BEAT_CNT, nb * 16); end
    tests++;
    if (CYC_CNT !== 32'(busy_cyc + 1)) begin fails++; $display("FAIL cyc_cnt got %0d exp %0d", CYC_CNT, busy_cyc + 1); end
`else
    tests++;
    if (CYC_CNT !== 32'd0 || BEAT_CNT !== 32'd0) begin
      fails++; $display("FAIL cnt_tied got %0d %0d exp 0 0", CYC_CNT, BEAT_CNT);
    end
`endif
    START_REG = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (RIDLE_REG !== 1'b1 || DONE !== 1'b0 || m_axi_arvalid !== 1'b0 || RERR !== 1'b0) begin
      fails++; $display("FAIL reset_state got ridle %b done %b arvalid %b rerr %b exp 1 0 0 0",
                        RIDLE_REG, DONE, m_axi_arvalid, RERR);
    end
    tests++;
    if (CYC_CNT !== 32'd0 || BEAT_CNT !== 32'd0) begin
      fails++; $display("FAIL reset_cnt got %0d %0d exp 0 0", CYC_CNT, BEAT_CNT);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    lat = 10; ar_mode = 0; tr_mode = 0; err_idx = -1;
    do_run(32'h0000_1000, 8, 1'b0, 1'b0);
  endtask

  task automatic test_nburst0();
    int d0;
    logic [2:0] exp_done, exp_idle;
    exp_done = 3'b010;
    exp_idle = 3'b101;
    ADDR_REG = 32'h0000_2000;
    NBURST_REG = 32'd0;
    @(posedge clk); #1;
    d0 = done_cnt; run_arv = 0;
    START_REG = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (DONE !== exp_done[k] || RIDLE_REG !== exp_idle[k]) begin
        fails++; $display("FAIL nburst0_seq step %0d got done %b ridle %b exp %b %b",
                          k, DONE, RIDLE_REG, exp_done[k], exp_idle[k]);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (run_arv != 0 || done_cnt - d0 != 1) begin
      fails++; $display("FAIL nburst0_ar got arvalid cycles %0d dones %0d exp 0 1", run_arv, done_cnt - d0);
    end
    START_REG = 1'b0;
  endtask

  task automatic test_ar_stall();
    lat = 6; tr_mode = 0; err_idx = -1;
    ar_stall = 20; ar_mode = 2;
    do_run(32'h0004_0080, 3, 1'b0, 1'b0);
    tests++;
    if (ar_stall != 0) begin fails++; $display("FAIL ar_stall_used got %0d left exp 0", ar_stall); end
    ar_mode = 0;
  endtask

  task automatic test_tready_toggle();
    lat = 4; ar_mode = 0; tr_mode = 1; err_idx = -1;
    do_run(32'h8000_0000, 4, 1'b0, 1'b0);
    tr_mode = 0;
  endtask

  task automatic test_rerr();
    lat = 10; ar_mode = 0; tr_mode = 0;
    err_idx = $urandom_range(0, 63);
    do_run(32'h0010_0000, 4, 1'b1, 1'b1);
    err_idx = -1;
    do_run(32'h0010_0400, 2, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midrun();
    int guard, d0;
    sb_en = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete();
    lat = 10; ar_mode = 0; tr_mode = 0; err_idx = -1;
    ADDR_REG = 32'h0020_0000;
    NBURST_REG = 32'd8;
    @(posedge clk); #1;
    run_ars = 0; d0 = done_cnt;
    START_REG = 1'b1;
    guard = 0;
    while (run_ars < 3 && guard < 200) begin @(posedge clk); #1; guard++; end
    tests++;
    if (guard >= 200) begin fails++; $display("FAIL rst_mid_wait got %0d ARs exp 3", run_ars); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (RIDLE_REG !== 1'b1 || m_axi_arvalid !== 1'b0 || DONE !== 1'b0) begin
      fails++; $display("FAIL rst_mid_state got ridle %b arvalid %b done %b exp 1 0 0",
                        RIDLE_REG, m_axi_arvalid, DONE);
    end
    @(posedge clk); #1;
    START_REG = 1'b0;
    guard = 0;
    while (ar_q.size() != 0 && guard < 1000) begin @(posedge clk); #1; guard++; end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (done_cnt != d0 || RIDLE_REG !== 1'b1 || m_axi_arvalid !== 1'b0 || guard >= 1000) begin
      fails++; $display("FAIL rst_mid_abandon got dones %0d ridle %b arvalid %b drain %0d exp 0 1 0 <1000",
                        done_cnt - d0, RIDLE_REG, m_axi_arvalid, guard);
    end
    sb_en = 1'b1;
    do_run(32'h0030_0000, 5, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 4; k++) begin
      a = (k == 0) ? 32'hFFFF_FF00 : ($urandom() & 32'hFFFF_FF80);
      lat = $urandom_range(1, 12);
      ar_mode = 1; tr_mode = 2; err_idx = -1;
      do_run(a, $urandom_range(1, 6), 1'b0, 1'b0);
    end
    ar_mode = 0; tr_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_nburst0();
    test_ar_stall();
    test_tready_toggle();
    test_rerr();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_mst_read_ot.md
AXI_MST_READ_OT -- requirements
Module: axi_mst_read_ot

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 6, AXI ID width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI/AXIS data width in bits (power of 2, 32..512).
REQ-003 SHALL have parameter B_BURST_LENGTH, default 4, width of m_axi_arlen.
REQ-004 SHALL have parameter BURST_LENGTH, default 15, arlen value; beats per burst = BURST_LENGTH+1.
REQ-005 SHALL have parameter MAX_OUTST, default 4, max outstanding read bursts (1..16).
REQ-006 Ports:
  clk  in  1  sole clock, all logic on rising edge.
  rst  in  1  synchronous reset, active-high.
  START_REG  in  1  level; rising edge requests a run.
  ADDR_REG  in  32  start byte address, aligned to (BURST_LENGTH+1)*DATA_WIDTH/8.
  NBURST_REG  in  32  bursts per run.
  RIDLE_REG  out  1  high in IDLE.
  DONE  out  1  one-cycle pulse at end of run.
  RERR  out  1  sticky flag: any rresp != 0 during run.
  m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out  AXI3 widths (len = B_BURST_LENGTH).
  m_axi_arready  in  1.
  m_axi_r{id,data,resp,last,valid}  in  AXI widths;  m_axi_rready  out  1.
  m_axis_t{valid,data,strb,last}  out;  m_axis_tready  in  1.
  CYC_CNT  out  32  run cycle count;  BEAT_CNT  out  32  accepted R beats.

Function
REQ-007 FSM states IDLE, ISSUE, DRAIN, DONE; reset state IDLE.
REQ-008 IDLE->ISSUE on START_REG rising edge (registered compare) with NBURST_REG != 0; latch ADDR_REG, NBURST_REG; clear RERR.
REQ-009 IDLE->DONE on START_REG rising edge with NBURST_REG == 0; no AR issued.
REQ-010 START_REG edges outside IDLE SHALL be ignored; latched values SHALL NOT change mid-run.
REQ-011 m_axi_arvalid high only in ISSUE while outstanding count < MAX_OUTST; held with stable payload until arready.
REQ-012 Each AR handshake: issued count +1, address += (BURST_LENGTH+1)*DATA_WIDTH/8 (32-bit wrap, no 4 KB splitting).
REQ-013 ISSUE->DRAIN on the AR handshake issuing the last burst.
REQ-014 Outstanding counter: +1 on AR handshake, -1 on R handshake with rlast; both same cycle -> unchanged; never exceeds MAX_OUTST.
REQ-015 DRAIN->DONE when outstanding count is 0; DONE->IDLE after one cycle; DONE output = (state==DONE).
REQ-016 Constant AR fields: arid 0, arlen BURST_LENGTH, arsize log2(DATA_WIDTH/8), arburst 2'b01, arlock 0, arcache 4'b0011, arprot 0, arqos 0.
REQ-017 R pass-through, zero latency: m_axis_tvalid=m_axi_rvalid, tdata=rdata, tlast=rlast, tstrb all ones, m_axi_rready=m_axis_tready.
REQ-018 RERR set on any R handshake with rresp != 0; held until next accepted start or reset.
REQ-019 Unexpected R beats in IDLE SHALL pass through but not decrement below 0.

Reset
REQ-020 rst high SHALL force IDLE, arvalid 0, counters 0, RERR 0, DONE 0, RIDLE_REG 1, CYC_CNT 0, BEAT_CNT 0 next edge.
REQ-021 rst mid-run SHALL abandon the run without DONE; in-flight R beats after reset handled per REQ-019.

Configuration
REQ-022 Macro AXI_MST_READ_OT_BW_CNT_EN defined: CYC_CNT counts cycles from start acceptance through DONE inclusive, BEAT_CNT counts R handshakes in run; both cleared at start, saturate at 0xFFFFFFFF, hold after DONE.
REQ-023 Macro undefined: counters not built, CYC_CNT and BEAT_CNT tied to 0.

Verification
REQ-024 NBURST=8, MAX_OUTST=4, arready/tready always 1, RD latency 10: 8 AR at ADDR, +128, ..+896; outstanding never >4; 128 beats; one DONE.
REQ-025 NBURST=0 start: DONE pulse 2 cycles after edge, no arvalid, RIDLE_REG back to 1.
REQ-026 arready held 0 for 20 cycles: arvalid and araddr stable throughout; run completes normally.
REQ-027 m_axis_tready toggled 50%: rready tracks tready, no beat lost, BEAT_CNT=(BURST_LENGTH+1)*NBURST (BW_CNT_EN).
REQ-028 rresp=2'b10 on one beat: RERR=1 after run, cleared on next start; START_REG edge mid-run ignored.
REQ-029 rst asserted after 3 AR issued: next cycle IDLE, arvalid 0, no DONE; new run then completes.
